// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants for the instruction/data memory arbiter.
//   - State encoding for the IDLE -> ISSUE -> RESP sequence.
//   - Default bound on consecutive contested data wins.
//   - Winner-select encoding (SEL_I / SEL_D).
//   - Helper that flags a non-word-aligned byte address.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_RESP  = 2'b10;

  localparam int MAX_DSTREAK_DEF = 4;

  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  // Word accesses only: any set bit in the byte offset is a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: winner selection plus the data-win streak counter.
//   clk, rst : clock and asynchronous active-high reset
//   i_req    : instruction-fetch request
//   d_req    : load/store request
//   pick     : an arbitration happens this edge (arbiter idle and a request up)
//   sel_d    : winner for this cycle, SEL_D when data wins, SEL_I otherwise
// Data wins ties until it has won MAX_DSTREAK contested rounds in a row; the
// next contested round then goes to instruction fetch. Any fetch win clears
// the streak; an uncontested data win leaves it untouched.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int MAX_DSTREAK = MAX_DSTREAK_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  input  logic pick,
  output logic sel_d
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          at_limit;

  assign at_limit = (streak_q == STREAK_MAX);

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    sel_d    = SEL_I;
    streak_d = streak_q;
    if (d_req && (!i_req || !at_limit)) begin
      sel_d = SEL_D;
    end
    if (pick) begin
      if (i_req && d_req) begin
        // Counter never exceeds STREAK_MAX: the limit round resets it.
        streak_d = at_limit ? '0 : streak_q + 1'b1;
      end else if (i_req) begin
        streak_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, synchronous-read memory between the
// instruction-fetch port and the load/store data port.
//   clk, rst                 : clock, asynchronous active-high reset
//   i_req/i_addr             : fetch request (held until i_gnt) and byte address
//   i_gnt/i_rvalid/i_err     : one-cycle accept / read-data-valid / misaligned pulses
//   i_rdata                  : read data, straight from m_rdata
//   d_req/d_we/d_addr/d_wdata: data request, store flag, byte address, store data
//   d_gnt/d_rvalid/d_err     : as for the fetch port
//   d_rdata                  : read data, straight from m_rdata
//   m_en/m_we/m_addr/m_wdata : memory enable, write enable, byte address, write data
//   m_rdata                  : memory read data, valid the cycle after a read enable
//   busy                     : arbiter not idle
//   arb_state                : current state, for monitoring
// Sequence: IDLE samples requests and latches the winner's access; ISSUE
// drives the memory and pulses gnt; RESP pulses rvalid or err. Aligned stores
// skip RESP. Misaligned accesses never enable the memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int MAX_DSTREAK = MAX_DSTREAK_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              busy,
  output logic [1:0]        arb_state
);

  logic [1:0]        state_q, state_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              mis_q, mis_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        pick;
  logic        win_sel;
  logic [31:0] req_addr;
  logic        in_issue, in_resp;
  logic        unused_addr_hi;

  assign pick     = (state_q == ST_IDLE) && (i_req || d_req);
  assign req_addr = (win_sel == SEL_D) ? d_addr : i_addr;

  // Only the low ADDR_W address bits reach the memory (ADDR_W is 2..31).
  assign unused_addr_hi = ^req_addr[31:ADDR_W];

  mem_arb_prio #(
    .MAX_DSTREAK(MAX_DSTREAK)
  ) u_prio (
    .clk  (clk),
    .rst  (rst),
    .i_req(i_req),
    .d_req(d_req),
    .pick (pick),
    .sel_d(win_sel)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    we_d    = we_q;
    mis_d   = mis_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick) begin
          state_d = ST_ISSUE;
          sel_d   = win_sel;
          addr_d  = req_addr[ADDR_W-1:0];
          we_d    = (win_sel == SEL_D) && d_we;
          mis_d   = is_misaligned(req_addr[1:0]);
          wdata_d = d_wdata;
        end
      end
      // An aligned store has nothing to report back, so it skips RESP.
      ST_ISSUE: state_d = (we_q && !mis_q) ? ST_IDLE : ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      wdata_q <= wdata_d;
    end
  end

  // All pulses decode from registered state, so reset clears them at once.
  assign in_issue = (state_q == ST_ISSUE);
  assign in_resp  = (state_q == ST_RESP);

  assign i_gnt    = in_issue && (sel_q == SEL_I);
  assign d_gnt    = in_issue && (sel_q == SEL_D);
  assign i_rvalid = in_resp && (sel_q == SEL_I) && !mis_q;
  assign d_rvalid = in_resp && (sel_q == SEL_D) && !mis_q;
  assign i_err    = in_resp && (sel_q == SEL_I) && mis_q;
  assign d_err    = in_resp && (sel_q == SEL_D) && mis_q;

  assign m_en    = in_issue && !mis_q;
  assign m_we    = in_issue && we_q && !mis_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  assign busy      = (state_q != ST_IDLE);
  assign arb_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a small
// synchronous-read memory model (128 words, ADDR_W = 9).
module tb_mem_arbiter;

  localparam int ADDR_W      = 9;
  localparam int MAX_DSTREAK = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt, i_rvalid, i_err;
  logic [31:0]       i_rdata;
  logic              d_req, d_we;
  logic [31:0]       d_addr, d_wdata;
  logic              d_gnt, d_rvalid, d_err;
  logic [31:0]       d_rdata;
  logic              m_en, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;
  logic              busy;
  logic [1:0]        arb_state;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .MAX_DSTREAK(MAX_DSTREAK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .i_err    (i_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .busy     (busy),
    .arb_state(arb_state)
  );

  // Memory model: word 1 (byte 0x004) preloaded while reset is high.
  logic [31:0] mem [0:127];
  always @(posedge clk) begin
    if (rst) begin
      mem[1] <= 32'h0050_0093;
    end else if (m_en) begin
      if (m_we) mem[m_addr[8:2]] <= m_wdata;
      else      m_rdata <= mem[m_addr[8:2]];
    end
  end

  // Control outputs packed: {i_gnt,i_rvalid,i_err,d_gnt,d_rvalid,d_err,m_en,m_we,busy}
  logic [8:0] ctl;
  assign ctl = {i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_en, m_we, busy};

  localparam logic [8:0] C_IDLE     = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] C_I_ISSUE  = 9'b1_0_0_0_0_0_1_0_1;
  localparam logic [8:0] C_I_RESP   = 9'b0_1_0_0_0_0_0_0_1;
  localparam logic [8:0] C_D_STORE  = 9'b0_0_0_1_0_0_1_1_1;
  localparam logic [8:0] C_D_LOAD   = 9'b0_0_0_1_0_0_1_0_1;
  localparam logic [8:0] C_D_RESP   = 9'b0_0_0_0_1_0_0_0_1;
  localparam logic [8:0] C_D_MIS    = 9'b0_0_0_1_0_0_0_0_1;
  localparam logic [8:0] C_D_ERR    = 9'b0_0_0_0_0_1_0_0_1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 1 = data grant, 0 = instruction grant, with both requests held.
  bit exp_d [0:9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", ctl, C_IDLE);
    check("reset_state", arb_state, 2'b00);
    check("reset_maddr", m_addr, 0);
    check("reset_mwdata", m_wdata, 0);
    rst = 1'b0;
    tick();

    // Instruction read of word 0x004.
    i_req = 1'b1; i_addr = 32'h0040_0004;
    tick();
    check("ifetch_issue_ctl", ctl, C_I_ISSUE);
    check("ifetch_issue_maddr", m_addr, 32'h004);
    check("ifetch_issue_state", arb_state, 2'b01);
    i_req = 1'b0;
    tick();
    check("ifetch_resp_ctl", ctl, C_I_RESP);
    check("ifetch_rdata", i_rdata, 32'h0050_0093);
    check("ifetch_resp_state", arb_state, 2'b10);
    tick();
    check("ifetch_idle_ctl", ctl, C_IDLE);

    // Store 0xDEADBEEF to 0x010: two cycles, no response.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    tick();
    check("store_issue_ctl", ctl, C_D_STORE);
    check("store_maddr", m_addr, 32'h010);
    check("store_mwdata", m_wdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    tick();
    check("store_idle_ctl", ctl, C_IDLE);
    check("store_idle_state", arb_state, 2'b00);

    // Load back from 0x010.
    d_req = 1'b1; d_we = 1'b0;
    tick();
    check("load_issue_ctl", ctl, C_D_LOAD);
    d_req = 1'b0;
    tick();
    check("load_resp_ctl", ctl, C_D_RESP);
    check("load_rdata", d_rdata, 32'hDEAD_BEEF);
    tick();

    // Starvation bound: both requests held continuously.
    i_req = 1'b1; i_addr = 32'h0040_0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    n = 0;
    for (int cyc = 0; cyc < 80 && n < 10; cyc++) begin
      tick();
      if (i_gnt || d_gnt) begin
        check($sformatf("starve_gnt%0d", n), {i_gnt, d_gnt}, exp_d[n] ? 2'b01 : 2'b10);
        n++;
      end
    end
    check("starve_grant_count", n, 10);
    i_req = 1'b0; d_req = 1'b0;
    tick();
    tick();
    check("starve_idle_ctl", ctl, C_IDLE);

    // Misaligned store to 0x013: granted, memory untouched, error pulse.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h13; d_wdata = 32'h1234_5678;
    tick();
    check("mis_issue_ctl", ctl, C_D_MIS);
    d_req = 1'b0;
    tick();
    check("mis_resp_ctl", ctl, C_D_ERR);
    tick();
    check("mis_idle_ctl", ctl, C_IDLE);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    tick();
    d_req = 1'b0;
    tick();
    check("mis_mem_kept", d_rdata, 32'hDEAD_BEEF);
    tick();

    // Reset asserted in ISSUE clears outputs with no clock edge.
    i_req = 1'b1; i_addr = 32'h0040_0004;
    tick();
    check("rst_issue_pre_ctl", ctl, C_I_ISSUE);
    i_req = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_issue_ctl", ctl, C_IDLE);
    check("rst_issue_state", arb_state, 2'b00);
    check("rst_issue_maddr", m_addr, 0);
    tick();
    rst = 1'b0;
    tick();

    // Build a full data streak, then reset during the last data read's RESP.
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      tick();
      if (i_gnt || d_gnt) begin
        check($sformatf("fill_gnt%0d", n), {i_gnt, d_gnt}, 2'b01);
        n++;
      end
    end
    check("fill_grant_count", n, 4);
    tick();
    check("fill_resp_ctl", ctl, C_D_RESP);
    rst = 1'b1;
    #1;
    check("rst_dresp_ctl", ctl, C_IDLE);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_streak_gnt", {i_gnt, d_gnt}, 2'b01);
    i_req = 1'b0; d_req = 1'b0;
    tick();
    tick();

    // Reset during RESP of an instruction read.
    i_req = 1'b1; i_addr = 32'h0040_0004;
    tick();
    i_req = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rst_iresp_rvalid", i_rvalid, 1'b0);
    check("rst_iresp_state", arb_state, 2'b00);
    tick();
    rst = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    tick();
    check("post_rst_first_gnt", {i_gnt, d_gnt}, 2'b01);
    i_req = 1'b0; d_req = 1'b0;
    tick();
    tick();
    check("final_idle_ctl", ctl, C_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
